bram_raster_reader: RTL and testbench

- Downstream consumer of the frame BRAM.
- On `start`, it scans one stored image in raster order by driving the BRAM's `ram_enable`/`address` ports.
- It absorbs the BRAM's 1-cycle read latency and emits a valid/ready pixel stream with frame and line markers.
- A 2-entry output buffer gives full throughput under continuous `out_ready` and lossless backpressure.

---
 rtl/bram_raster_reader.sv | 140 ++++++++++++++
 tb/tb_bram_raster_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_raster_reader.sv
// Raster-order frame reader for a 1-cycle-latency BRAM. It emits a valid/ready pixel
// stream with sof/eol/eof markers, using a 2-entry skid FIFO for full-rate lossless backpressure.
module bram_raster_reader #(
    parameter int unsigned PIXEL_WIDTH = 16,
    parameter int unsigned ADDR_BITS   = 17,
    parameter int unsigned IMG_WIDTH   = 256,
    parameter int unsigned IMG_HEIGHT  = 128,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   ram_enable,
    output logic [ADDR_BITS-1:0]   address,
    input  logic [PIXEL_WIDTH-1:0] ram_data,
    output logic [PIXEL_WIDTH-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sof,
    output logic                   out_eol,
    output logic                   out_eof
);

    localparam int unsigned XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int unsigned YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [PIXEL_WIDTH-1:0] data;
        logic                   sof;
        logic                   eol;
        logic                   eof;
    } pix_t;

    state_t               r_state;
    state_t               w_next;
    logic [XW-1:0]        r_x;
    logic [YW-1:0]        r_y;
    logic [ADDR_BITS-1:0] r_addr;
    logic                 r_inflight;
    logic [2:0]           r_tag;
    pix_t                 r_mem [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;

    logic                 w_issue;
    logic                 w_pop;
    logic                 w_last_x;
    logic                 w_last_y;
    logic                 w_valid;
    pix_t                 w_head;

    assign w_valid  = (r_count != 2'd0);
    assign w_pop    = w_valid & out_ready;
    assign w_last_x = (r_x == XW'(IMG_WIDTH - 1));
    assign w_last_y = (r_y == YW'(IMG_HEIGHT - 1));
    assign w_head   = r_mem[r_rd_ptr];

    // Next state; a read is issued only if the FIFO can still absorb it after this cycle's pop
    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                w_issue = ({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
                if (w_issue && w_last_x && w_last_y) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!r_inflight && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)))
                    w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_addr     <= '0;
            r_inflight <= 1'b0;
            r_tag      <= '0;
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state <= w_next;

            if (r_state == S_IDLE) begin
                r_x    <= '0;
                r_y    <= '0;
                r_addr <= ADDR_BITS'(BASE_ADDR);
            end else if (w_issue) begin
                r_addr <= r_addr + ADDR_BITS'(1);
                if (w_last_x) begin
                    r_x <= '0;
                    r_y <= w_last_y ? '0 : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end

            // Tags travel with the read so they land in the FIFO alongside ram_data
            r_inflight <= w_issue;
            if (w_issue)
                r_tag <= {(r_x == '0) && (r_y == '0), w_last_x, w_last_x && w_last_y};

            if (r_inflight) begin
                r_mem[r_wr_ptr] <= {ram_data, r_tag};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    assign ram_enable = w_issue;
    assign address    = r_addr;
    assign busy       = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign done       = (r_state == S_DONE);
    assign out_valid  = w_valid;
    assign out_data   = w_head.data;
    assign out_sof    = w_head.sof & w_valid;
    assign out_eol    = w_head.eol & w_valid;
    assign out_eof    = w_head.eof & w_valid;

endmodule

// File: tb/tb_bram_raster_reader.sv
// Scoreboard bench for bram_raster_reader: three instances (4x2 @0x10, 4x1 wrapping @0x1FFFE, 1x1 @5),
// each backed by a behavioural BRAM returning data = address[15:0].
module tb_bram_raster_reader;

    localparam int PW = 16;
    localparam int AW = 17;

    logic          clock = 1'b0;
    logic          reset;
    logic [2:0]    start_v;
    logic [2:0]    busy_v, done_v, en_v, valid_v, sof_v, eol_v, eof_v;
    logic [AW-1:0] addr_v [3];
    logic [PW-1:0] data_v [3];
    logic          out_ready;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned W = (g == 2) ? 1 : 4;
        localparam int unsigned H = (g == 0) ? 2 : 1;
        localparam int unsigned B = (g == 0) ? 32'h10 : ((g == 1) ? 32'h1FFFE : 32'h5);
        logic [PW-1:0] rdata;

        always_ff @(posedge clock) begin
            if (en_v[g]) rdata <= addr_v[g][PW-1:0];
        end

        bram_raster_reader #(
            .PIXEL_WIDTH(PW), .ADDR_BITS(AW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .BASE_ADDR(B)
        ) u_dut (
            .clock      (clock),
            .reset      (reset),
            .start      (start_v[g]),
            .busy       (busy_v[g]),
            .done       (done_v[g]),
            .ram_enable (en_v[g]),
            .address    (addr_v[g]),
            .ram_data   (rdata),
            .out_data   (data_v[g]),
            .out_valid  (valid_v[g]),
            .out_ready  (out_ready),
            .out_sof    (sof_v[g]),
            .out_eol    (eol_v[g]),
            .out_eof    (eof_v[g])
        );
    end

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            c0;
    int            issued, popped, n_done;
    int            first_en, last_en, first_val, last_hs, done_cyc;
    logic [AW-1:0] exp_addr;
    logic [18:0]   exp_q [$];
    logic [18:0]   prev_word [3];
    logic          prev_stall [3];
    logic          rdy_mode = 1'b0;
    int            rp = 0;
    int            pat [6] = '{1, 0, 0, 1, 0, 1};

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: address sequence, occupancy bound, stall stability and scoreboard pops
    always @(negedge clock) begin
        for (int g = 0; g < 3; g++) begin
            logic [18:0] w;
            logic [18:0] e;
            w = {data_v[g], sof_v[g], eol_v[g], eof_v[g]};
            if (en_v[g] || (valid_v[g] && out_ready))
                check("occupancy<=2", 32'((issued - popped) <= 2), 32'd1);
            if (en_v[g]) begin
                check("address", 32'(addr_v[g]), 32'(exp_addr));
                exp_addr = exp_addr + AW'(1);
                issued++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
            end
            if (prev_stall[g])
                check("stall hold", 32'({valid_v[g], w}), 32'({1'b1, prev_word[g]}));
            if (valid_v[g] && out_ready) begin
                if (first_val < 0) first_val = cyc;
                if (exp_q.size() == 0) begin
                    check("extra pixel", 32'(valid_v[g]), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel {data,sof,eol,eof}", 32'(w), 32'(e));
                end
                popped++;
                last_hs = cyc;
            end
            prev_stall[g] = valid_v[g] && !out_ready;
            prev_word[g]  = w;
            if (done_v[g]) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        if (rdy_mode) begin
            out_ready = pat[rp % 6][0];
            rp++;
        end else begin
            out_ready = 1'b1;
        end
    endtask

    task automatic reset_model();
        issued = 0; popped = 0; n_done = 0;
        first_en = -1; last_en = -1; first_val = -1; last_hs = -1; done_cyc = -1;
        exp_q.delete();
    endtask

    task automatic push_frame(input int w, input int h, input logic [AW-1:0] base);
        logic [AW-1:0] a;
        exp_addr = base;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                a = base + AW'(y * w + x);
                exp_q.push_back({a[PW-1:0], (x == 0) && (y == 0), x == w - 1, (x == w - 1) && (y == h - 1)});
            end
        end
    endtask

    task automatic run_start(input int g);
        start_v[g] = 1'b1;
        c0 = cyc;
        step();
        start_v[g] = 1'b0;
    endtask

    task automatic wait_frame(input int g, input int npix, input int budget);
        int k = 0;
        while (!(n_done > 0 && done_v[g] == 1'b0) && k < budget) begin
            step();
            k++;
        end
        check("frame timeout", 32'(k < budget), 32'd1);
        check("pixel count", 32'(popped), 32'(npix));
        check("done pulses", 32'(n_done), 32'd1);
        check("queue empty", 32'(exp_q.size()), 32'd0);
        check("busy low after done", 32'(busy_v[g]), 32'd0);
    endtask

    task automatic check_zero(input string tag, input int g);
        check({tag, " flags"}, 32'({busy_v[g], done_v[g], en_v[g], valid_v[g], sof_v[g], eol_v[g], eof_v[g]}), 32'd0);
        check({tag, " address"}, 32'(addr_v[g]), 32'd0);
        check({tag, " out_data"}, 32'(data_v[g]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        start_v   = '0;
        out_ready = 1'b1;
        for (int g = 0; g < 3; g++) begin
            prev_stall[g] = 1'b0;
            prev_word[g]  = '0;
        end
        reset_model();
        exp_addr = '0;
        #1;
        check_zero("reset", 0);
        repeat (3) step();
        reset = 1'b0;
        step();

        // Full-rate 4x2 frame: latency, consecutive issue/output, done timing
        reset_model();
        push_frame(4, 2, AW'(32'h10));
        run_start(0);
        wait_frame(0, 8, 60);
        check("first ram_enable cycle", 32'(first_en - c0), 32'd1);
        check("last ram_enable cycle", 32'(last_en - c0), 32'd8);
        check("first out_valid cycle", 32'(first_val - c0), 32'd3);
        check("last handshake cycle", 32'(last_hs - c0), 32'd10);
        check("done after last handshake", 32'(done_cyc - last_hs), 32'd1);

        // Backpressure with ready pattern 1,0,0,1,0,1,...
        rdy_mode = 1'b1;
        rp = 0;
        reset_model();
        push_frame(4, 2, AW'(32'h10));
        run_start(0);
        wait_frame(0, 8, 200);
        rdy_mode = 1'b0;
        step();

        // Address wrap past 2**17-1
        reset_model();
        push_frame(4, 1, AW'(32'h1FFFE));
        run_start(1);
        wait_frame(1, 4, 60);

        // Start while busy and in the DONE cycle are ignored
        reset_model();
        push_frame(4, 2, AW'(32'h10));
        run_start(0);
        repeat (3) step();
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        begin
            int k = 0;
            while (!done_v[0] && k < 100) begin
                @(negedge clock);
                #1;
                k++;
            end
            check("done seen", 32'(done_v[0]), 32'd1);
        end
        start_v[0] = 1'b1;
        @(posedge clock);
        #1;
        start_v[0] = 1'b0;
        repeat (20) step();
        check("one frame pixels", 32'(popped), 32'd8);
        check("one frame reads", 32'(issued), 32'd8);
        check("one frame done", 32'(n_done), 32'd1);
        check("idle after frame", 32'(busy_v[0]), 32'd0);

        // Reset mid-frame after 3 pixels
        reset_model();
        push_frame(4, 2, AW'(32'h10));
        run_start(0);
        begin
            int k = 0;
            while (popped < 3 && k < 50) begin
                @(negedge clock);
                #1;
                k++;
            end
            check("reached 3 pixels", 32'(popped), 32'd3);
        end
        reset = 1'b1;
        #1;
        check_zero("async reset", 0);
        reset_model();
        repeat (2) step();
        reset = 1'b0;
        repeat (12) step();
        check("no pixel after reset", 32'(popped), 32'd0);
        check("no read after reset", 32'(issued), 32'd0);
        check("idle after reset", 32'(busy_v[0]), 32'd0);
        push_frame(4, 2, AW'(32'h10));
        run_start(0);
        wait_frame(0, 8, 60);

        // 1x1 image
        reset_model();
        push_frame(1, 1, AW'(32'h5));
        run_start(2);
        wait_frame(2, 1, 30);
        check("1x1 first out_valid cycle", 32'(first_val - c0), 32'd3);
        check("1x1 done after handshake", 32'(done_cyc - last_hs), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
